// File: rtl/mysystem_ram_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : mysystem_ram_arbiter_if
// Brief    : Requester (m0/m1), shared-RAM and error-flag signal bundle.
// Revision : 1.0 - initial release
// ============================================================================
interface mysystem_ram_arbiter_if #(
  parameter int ADDR_W = 12
);
  logic [ADDR_W-1:0] m0_address;
  logic [3:0]        m0_byteenable;
  logic              m0_read;
  logic              m0_write;
  logic [31:0]       m0_writedata;
  logic              m0_waitrequest;
  logic [31:0]       m0_readdata;
  logic              m0_readdatavalid;

  logic [ADDR_W-1:0] m1_address;
  logic [3:0]        m1_byteenable;
  logic              m1_read;
  logic              m1_write;
  logic [31:0]       m1_writedata;
  logic              m1_waitrequest;
  logic [31:0]       m1_readdata;
  logic              m1_readdatavalid;

  logic [ADDR_W-1:0] ram_address;
  logic [3:0]        ram_byteenable;
  logic [31:0]       ram_writedata;
  logic              ram_chipselect;
  logic              ram_write;
  logic [31:0]       ram_readdata;

  logic              err_oor;
  logic              err_clr;

  modport slave (
    input  m0_address, m0_byteenable, m0_read, m0_write, m0_writedata,
    output m0_waitrequest, m0_readdata, m0_readdatavalid,
    input  m1_address, m1_byteenable, m1_read, m1_write, m1_writedata,
    output m1_waitrequest, m1_readdata, m1_readdatavalid,
    output ram_address, ram_byteenable, ram_writedata, ram_chipselect, ram_write,
    input  ram_readdata,
    output err_oor,
    input  err_clr
  );

  modport master (
    output m0_address, m0_byteenable, m0_read, m0_write, m0_writedata,
    input  m0_waitrequest, m0_readdata, m0_readdatavalid,
    output m1_address, m1_byteenable, m1_read, m1_write, m1_writedata,
    input  m1_waitrequest, m1_readdata, m1_readdatavalid,
    input  ram_address, ram_byteenable, ram_writedata, ram_chipselect, ram_write,
    output ram_readdata,
    input  err_oor,
    output err_clr
  );
endinterface
`default_nettype wire

// File: rtl/mysystem_ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mysystem_ram_arbiter
// Brief    : Two-port fixed-priority RAM arbiter (m1 preferred) with m0
//            starvation guard, range check and 1-cycle read return routing.
// Revision : 1.0 - initial release
// ============================================================================
module mysystem_ram_arbiter #(
  parameter int DEPTH        = 3250,
  parameter int ADDR_W       = 12,
  parameter int STARVE_LIMIT = 4
) (
  input  wire logic                clk,
  input  wire logic                reset,
  mysystem_ram_arbiter_if.slave    bus
);

  localparam logic [3:0]  c_STARVE_LIMIT = 4'(STARVE_LIMIT);
  localparam logic [31:0] c_DEPTH        = 32'(DEPTH);

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_M0   = 2'd1,
    GNT_M1   = 2'd2
  } grant_e;

  grant_e            w_grant;
  logic              w_m0_req;
  logic              w_m1_req;
  logic              w_force_m0;
  logic              w_gnt_any;
  logic              w_in_range;
  logic [ADDR_W-1:0] w_sel_addr;
  logic [3:0]        w_sel_be;
  logic [31:0]       w_sel_wdata;
  logic              w_sel_wr;
  logic              w_sel_rd;
  logic              w_rd_valid;
  logic [31:0]       w_rd_word;

  logic [3:0]        r_starve_cnt;
  logic              r_rd_pending;
  logic              r_rd_owner;
  logic              r_rd_oor;
  logic              r_err_oor;

  assign w_m0_req   = bus.m0_read | bus.m0_write;
  assign w_m1_req   = bus.m1_read | bus.m1_write;
  assign w_force_m0 = w_m0_req && (r_starve_cnt == c_STARVE_LIMIT);

  always_comb begin
    w_grant = GNT_NONE;
    if (!reset) begin
      if (w_force_m0)    w_grant = GNT_M0;
      else if (w_m1_req) w_grant = GNT_M1;
      else if (w_m0_req) w_grant = GNT_M0;
    end
  end

  // Read+write on one port collapses to a write.
  always_comb begin
    w_sel_addr  = '0;
    w_sel_be    = 4'h0;
    w_sel_wdata = 32'h0;
    w_sel_wr    = 1'b0;
    w_sel_rd    = 1'b0;
    case (w_grant)
      GNT_M0: begin
        w_sel_addr  = bus.m0_address;
        w_sel_be    = bus.m0_byteenable;
        w_sel_wdata = bus.m0_writedata;
        w_sel_wr    = bus.m0_write;
        w_sel_rd    = bus.m0_read & ~bus.m0_write;
      end
      GNT_M1: begin
        w_sel_addr  = bus.m1_address;
        w_sel_be    = bus.m1_byteenable;
        w_sel_wdata = bus.m1_writedata;
        w_sel_wr    = bus.m1_write;
        w_sel_rd    = bus.m1_read & ~bus.m1_write;
      end
      default: ;
    endcase
  end

  assign w_gnt_any  = (w_grant != GNT_NONE);
  assign w_in_range = (32'(w_sel_addr) < c_DEPTH);

  assign bus.ram_address    = w_sel_addr;
  assign bus.ram_byteenable = w_sel_be;
  assign bus.ram_writedata  = w_sel_wdata;
  assign bus.ram_chipselect = w_gnt_any & w_in_range;
  assign bus.ram_write      = w_gnt_any & w_in_range & w_sel_wr;

  assign bus.m0_waitrequest = reset | (w_m0_req & (w_grant != GNT_M0));
  assign bus.m1_waitrequest = reset | (w_m1_req & (w_grant != GNT_M1));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_starve_cnt <= 4'd0;
      r_rd_pending <= 1'b0;
      r_rd_owner   <= 1'b0;
      r_rd_oor     <= 1'b0;
      r_err_oor    <= 1'b0;
    end else begin
      if (w_m0_req && (w_grant != GNT_M0)) begin
        if (r_starve_cnt != 4'hF) r_starve_cnt <= r_starve_cnt + 4'd1;
      end else begin
        r_starve_cnt <= 4'd0;
      end
      r_rd_pending <= w_gnt_any & w_sel_rd;
      r_rd_owner   <= (w_grant == GNT_M1);
      r_rd_oor     <= ~w_in_range;
      // A fresh out-of-range grant outranks a simultaneous clear.
      if (w_gnt_any && !w_in_range) r_err_oor <= 1'b1;
      else if (bus.err_clr)         r_err_oor <= 1'b0;
    end
  end

  assign w_rd_valid = r_rd_pending & ~reset;
  assign w_rd_word  = r_rd_oor ? 32'h0 : bus.ram_readdata;

  assign bus.m0_readdatavalid = w_rd_valid & ~r_rd_owner;
  assign bus.m1_readdatavalid = w_rd_valid &  r_rd_owner;
  assign bus.m0_readdata      = (w_rd_valid & ~r_rd_owner) ? w_rd_word : 32'h0;
  assign bus.m1_readdata      = (w_rd_valid &  r_rd_owner) ? w_rd_word : 32'h0;
  assign bus.err_oor          = r_err_oor;

endmodule
`default_nettype wire
